servo_pwm_capture: RTL and testbench
====================================

// Module: servo_pwm_capture
// PURPOSE
//  Measures the high time of an incoming 50 Hz servo-style PWM signal (RC receiver or loopback
//  from the servo PWM generator) in 1 us units and converts it back to an angle 0..180 using the
//  inverse of the team's servo encoding (high_us = 500 + 11*angle). Sits on the input side of the
//  robot controller; its angle_out feeds the same angle bus the servo drivers consume.
// PARAMETERS
//  CLK_FREQ        100    clk cycles per 1 us tick
//  MIN_HIGH_US     400    shortest accepted high time (us); shorter -> range error
//  MAX_HIGH_US     2600   longest accepted high time (us); longer -> range error, abort
//  LOST_TIMEOUT_US 25000  us without a rising edge before signal_lost asserts
// PORTS
//  clk            in   1   system clock
//  reset_n        in   1   asynchronous reset, active low
//  pwm_in         in   1   asynchronous PWM input pin
//  high_dur_out   out  15  last valid measured high time, us
//  angle_out      out  8   last valid decoded angle, 0..180
//  valid          out  1   1-clk pulse: new high_dur_out/angle_out loaded this cycle
//  range_err      out  1   1-clk pulse: pulse rejected (too short or too long)
//  signal_lost    out  1   level: no rising edge for LOST_TIMEOUT_US
// BEHAVIOUR
//  Reset: high_dur_out=0, angle_out=0, valid=0, range_err=0, signal_lost=1, sync FFs=0, state=ARM.
//  Input: 2-FF synchronizer then edge detect; rise/fall seen 3 clks after pin edge (equal delay).
//  Prescaler 0..CLK_FREQ-1 gives tick; prescaler cleared on detected rise. Pulse of exactly N us
//   (N*CLK_FREQ clks) measures exactly N.
//  lost_cnt (15b): counts ticks, cleared on detected rise; saturates at LOST_TIMEOUT_US, where
//   signal_lost<=1. signal_lost clears only on a valid pulse.
//  FSM:
//   ARM       : wait for synced input low (never capture a pulse already high) -> WAIT_RISE.
//   WAIT_RISE : on rise: high_cnt<=0 -> HIGH.
//   HIGH      : high_cnt++ per tick. On fall: if high_cnt<MIN_HIGH_US -> range_err, WAIT_RISE;
//               else latch hd=high_cnt -> CONV. If high_cnt exceeds MAX_HIGH_US (tick making it
//               MAX_HIGH_US+1) before fall -> range_err, ARM.
//   CONV      : rem<=(hd<500 ? 0 : hd-500)+5, q<=0 on entry; each clk while rem>=11 and q<180:
//               rem-=11, q++. When done: angle_out<=q, high_dur_out<=hd, valid=1,
//               signal_lost<=0 -> WAIT_RISE. Result = min(180, floor((hd-500+5)/11)) (rounded).
//               Max 181 clks + 1 entry clk; edges detected during CONV are ignored.
//  Outputs hold last valid values across range errors and signal loss.
//  Widths: all us counters 15 bits unsigned; no wrap since MAX_HIGH_US and LOST_TIMEOUT_US
//   < 32767 and counters stop/saturate at their limits.
//  reset_n asserted mid-pulse/mid-CONV: immediate return to reset values; a pulse high at
//   release is skipped (ARM), next full pulse is captured.
// TESTING (CLK_FREQ=100, 20 ms period)
//  1490 us high -> valid pulse, high_dur_out=1490, angle_out=90; signal_lost 1->0.
//  Sweep a=0..180 with high=500+11a -> angle_out==a every time (round trip with encoder).
//  500 us -> angle 0; 2480 us -> 180; 2600 us -> high_dur_out=2600, angle clamped 180.
//  300 us pulse -> range_err 1 clk, no valid, outputs unchanged; 2700 us stuck high ->
//   range_err at tick 2601, fall ignored, next 1490 us pulse decodes 90.
//  Input held low 25 ms after a valid pulse -> signal_lost=1 at tick 25000; next pulse clears it.
//  reset_n low for 5 clks mid-pulse -> all outputs at reset values; remainder of that pulse
//   ignored; following 1000 us pulse -> high_dur_out=1000, angle_out=45.

Source files
------------

// File: rtl/servo_pwm_capture.sv
// rtl/servo_pwm_capture.sv - servo PWM high-time capture and angle decoder
//
// Purpose:
//   Measures the high time of a servo-style PWM input in 1 us units and
//   decodes it back to an angle 0..180 using the inverse of the encoding
//   high_us = 500 + 11*angle (rounded to nearest, clamped at 180).
//
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous reset, active low
//   pwm_in        in   asynchronous PWM input pin
//   high_dur_out  out  [14:0] last valid measured high time, us
//   angle_out     out  [7:0]  last valid decoded angle, 0..180
//   valid         out  1-clk pulse: new high_dur_out/angle_out loaded
//   range_err     out  1-clk pulse: pulse rejected (too short or too long)
//   signal_lost   out  level: no rising edge for LOST_TIMEOUT_US

module servo_pwm_capture #(
  parameter int CLK_FREQ        = 100,
  parameter int MIN_HIGH_US     = 400,
  parameter int MAX_HIGH_US     = 2600,
  parameter int LOST_TIMEOUT_US = 25000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pwm_in,
  output logic [14:0] high_dur_out,
  output logic [7:0]  angle_out,
  output logic        valid,
  output logic        range_err,
  output logic        signal_lost
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
  localparam logic [14:0]   MIN_US    = 15'(MIN_HIGH_US);
  localparam logic [14:0]   MAX_US    = 15'(MAX_HIGH_US);
  localparam logic [14:0]   LOST_US   = 15'(LOST_TIMEOUT_US);
  localparam logic [14:0]   ZERO_US   = 15'd500;
  localparam logic [14:0]   STEP_US   = 15'd11;
  localparam logic [14:0]   ROUND_US  = 15'd5;
  localparam logic [7:0]    MAX_ANGLE = 8'd180;

  typedef enum logic [1:0] {
    ARM       = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    CONV      = 2'd3
  } state_t;

  state_t        state;
  logic          sync1;
  logic          sync2;
  logic          sync_d;
  logic [1:0]    settle_cnt;
  logic [PW-1:0] presc;
  logic [14:0]   lost_cnt;
  logic [14:0]   high_cnt;
  logic [14:0]   hd;
  logic [14:0]   rem;
  logic [7:0]    q;
  logic          conv_first;

  logic          rise;
  logic          fall;
  logic          tick;
  logic [14:0]   high_next;

  assign rise = sync2 & ~sync_d;
  assign fall = ~sync2 & sync_d;
  assign tick = (presc == PRESC_MAX);

  // Count the tick that coincides with the fall so an N us pulse reads N.
  assign high_next = high_cnt + {14'd0, tick};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ARM;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync_d       <= 1'b0;
      settle_cnt   <= 2'd0;
      presc        <= '0;
      lost_cnt     <= 15'd0;
      high_cnt     <= 15'd0;
      hd           <= 15'd0;
      rem          <= 15'd0;
      q            <= 8'd0;
      conv_first   <= 1'b0;
      high_dur_out <= 15'd0;
      angle_out    <= 8'd0;
      valid        <= 1'b0;
      range_err    <= 1'b0;
      signal_lost  <= 1'b1;
    end else begin
      sync1  <= pwm_in;
      sync2  <= sync1;
      sync_d <= sync2;

      // sync2 only reflects the pin two clocks after reset release; until
      // then its reset value would look like a low input.
      if (settle_cnt != 2'd2) begin
        settle_cnt <= settle_cnt + 2'd1;
      end

      valid     <= 1'b0;
      range_err <= 1'b0;

      if (rise || tick) begin
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end

      if (rise) begin
        lost_cnt <= 15'd0;
      end else if (tick && (lost_cnt < LOST_US)) begin
        lost_cnt <= lost_cnt + 15'd1;
        if (lost_cnt == LOST_US - 15'd1) begin
          signal_lost <= 1'b1;
        end
      end

      case (state)
        ARM: begin
          // Never start measuring a pulse that was already high.
          if ((settle_cnt == 2'd2) && !sync2) begin
            state <= WAIT_RISE;
          end
        end

        WAIT_RISE: begin
          if (rise) begin
            high_cnt <= 15'd0;
            state    <= HIGH;
          end
        end

        HIGH: begin
          if (high_next > MAX_US) begin
            range_err <= 1'b1;
            state     <= ARM;
          end else if (fall) begin
            if (high_next < MIN_US) begin
              range_err <= 1'b1;
              state     <= WAIT_RISE;
            end else begin
              hd         <= high_next;
              conv_first <= 1'b1;
              state      <= CONV;
            end
          end else begin
            high_cnt <= high_next;
          end
        end

        CONV: begin
          // Divide (hd - 500 + 5) by 11 by repeated subtraction; the +5
          // rounds to the nearest angle of the encoder.
          if (conv_first) begin
            conv_first <= 1'b0;
            rem        <= ((hd < ZERO_US) ? 15'd0 : (hd - ZERO_US)) + ROUND_US;
            q          <= 8'd0;
          end else if ((rem >= STEP_US) && (q < MAX_ANGLE)) begin
            rem <= rem - STEP_US;
            q   <= q + 8'd1;
          end else begin
            angle_out    <= q;
            high_dur_out <= hd;
            valid        <= 1'b1;
            signal_lost  <= 1'b0;
            state        <= WAIT_RISE;
          end
        end

        default: state <= ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// tb/tb_servo_pwm_capture.sv - directed self-checking bench for servo_pwm_capture

module tb_servo_pwm_capture;

  localparam int CF      = 2;
  localparam int LOST_US = 3000;
  localparam int SETTLE  = 260;

  logic        clk;
  logic        rst_n;
  logic        pwm;
  logic [14:0] high_dur_out;
  logic [7:0]  angle_out;
  logic        valid;
  logic        range_err;
  logic        signal_lost;

  int tests;
  int fails;
  int valid_cnt;
  int err_cnt;

  servo_pwm_capture #(
    .CLK_FREQ(CF),
    .MIN_HIGH_US(400),
    .MAX_HIGH_US(2600),
    .LOST_TIMEOUT_US(LOST_US)
  ) dut (
    .clk(clk),
    .reset_n(rst_n),
    .pwm_in(pwm),
    .high_dur_out(high_dur_out),
    .angle_out(angle_out),
    .valid(valid),
    .range_err(range_err),
    .signal_lost(signal_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) valid_cnt++;
    if (range_err) err_cnt++;
  end

  task automatic send_pulse(input int us);
    @(negedge clk);
    pwm = 1'b1;
    repeat (us * CF) @(negedge clk);
    pwm = 1'b0;
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pwm   = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (high_dur_out !== 15'd0) begin fails++; $display("FAIL reset_hd: got %0d expected 0", high_dur_out); end
    tests++; if (angle_out !== 8'd0) begin fails++; $display("FAIL reset_angle: got %0d expected 0", angle_out); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid); end
    tests++; if (range_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", range_err); end
    tests++; if (signal_lost !== 1'b1) begin fails++; $display("FAIL reset_lost: got %b expected 1", signal_lost); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    tests++; if (signal_lost !== 1'b1) begin fails++; $display("FAIL post_reset_lost: got %b expected 1", signal_lost); end
  endtask

  task automatic test_center();
    int v0;
    v0 = valid_cnt;
    send_pulse(1490);
    tests++; if (valid_cnt !== v0 + 1) begin fails++; $display("FAIL center_valid_count: got %0d expected %0d", valid_cnt - v0, 1); end
    tests++; if (high_dur_out !== 15'd1490) begin fails++; $display("FAIL center_hd: got %0d expected 1490", high_dur_out); end
    tests++; if (angle_out !== 8'd90) begin fails++; $display("FAIL center_angle: got %0d expected 90", angle_out); end
    tests++; if (signal_lost !== 1'b0) begin fails++; $display("FAIL center_lost: got %b expected 0", signal_lost); end
  endtask

  task automatic test_sweep();
    int angles [7] = '{0, 1, 44, 91, 135, 179, 180};
    int v0;
    for (int i = 0; i < 7; i++) begin
      v0 = valid_cnt;
      send_pulse(500 + 11 * angles[i]);
      tests++; if (valid_cnt !== v0 + 1) begin fails++; $display("FAIL sweep_valid a=%0d: got %0d expected 1", angles[i], valid_cnt - v0); end
      tests++; if (angle_out !== 8'(angles[i])) begin fails++; $display("FAIL sweep_angle: got %0d expected %0d", angle_out, angles[i]); end
      tests++; if (high_dur_out !== 15'(500 + 11 * angles[i])) begin fails++; $display("FAIL sweep_hd: got %0d expected %0d", high_dur_out, 500 + 11 * angles[i]); end
    end
  endtask

  task automatic test_limits();
    int us_tab  [4] = '{400, 500, 2480, 2600};
    int ang_tab [4] = '{0, 0, 180, 180};
    int v0;
    int e0;
    for (int i = 0; i < 4; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      send_pulse(us_tab[i]);
      tests++; if (valid_cnt !== v0 + 1 || err_cnt !== e0) begin fails++; $display("FAIL limit_flags us=%0d: got valid %0d err %0d expected 1 0", us_tab[i], valid_cnt - v0, err_cnt - e0); end
      tests++; if (high_dur_out !== 15'(us_tab[i])) begin fails++; $display("FAIL limit_hd: got %0d expected %0d", high_dur_out, us_tab[i]); end
      tests++; if (angle_out !== 8'(ang_tab[i])) begin fails++; $display("FAIL limit_angle us=%0d: got %0d expected %0d", us_tab[i], angle_out, ang_tab[i]); end
    end
  endtask

  task automatic test_range_short();
    int us_tab [2] = '{300, 399};
    int v0;
    int e0;
    for (int i = 0; i < 2; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      send_pulse(us_tab[i]);
      tests++; if (err_cnt !== e0 + 1) begin fails++; $display("FAIL short_err us=%0d: got %0d expected 1", us_tab[i], err_cnt - e0); end
      tests++; if (valid_cnt !== v0) begin fails++; $display("FAIL short_no_valid us=%0d: got %0d expected 0", us_tab[i], valid_cnt - v0); end
      tests++; if (high_dur_out !== 15'd2600 || angle_out !== 8'd180) begin fails++; $display("FAIL short_hold: got %0d/%0d expected 2600/180", high_dur_out, angle_out); end
    end
  endtask

  task automatic test_stuck_high();
    int v0;
    int e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_pulse(2700);
    tests++; if (err_cnt !== e0 + 1) begin fails++; $display("FAIL stuck_err: got %0d expected 1", err_cnt - e0); end
    tests++; if (valid_cnt !== v0) begin fails++; $display("FAIL stuck_no_valid: got %0d expected 0", valid_cnt - v0); end
    tests++; if (high_dur_out !== 15'd2600) begin fails++; $display("FAIL stuck_hold_hd: got %0d expected 2600", high_dur_out); end
    send_pulse(1490);
    tests++; if (valid_cnt !== v0 + 1) begin fails++; $display("FAIL stuck_recover_valid: got %0d expected 1", valid_cnt - v0); end
    tests++; if (angle_out !== 8'd90) begin fails++; $display("FAIL stuck_recover_angle: got %0d expected 90", angle_out); end
  endtask

  task automatic test_signal_lost();
    int v0;
    v0 = valid_cnt;
    @(negedge clk);
    pwm = 1'b1;
    // The rise is seen 3 clocks after the pin edge; signal_lost follows
    // LOST_US ticks (LOST_US*CF clocks) later.
    for (int n = 1; n <= 2 + LOST_US * CF + 1; n++) begin
      @(negedge clk);
      if (n == 1490 * CF) pwm = 1'b0;
      if (n == 4000) begin
        tests++; if (valid_cnt !== v0 + 1 || signal_lost !== 1'b0) begin fails++; $display("FAIL lost_pre_pulse: got valid %0d lost %b expected 1 0", valid_cnt - v0, signal_lost); end
      end
      if (n == 2 + LOST_US * CF) begin
        tests++; if (signal_lost !== 1'b0) begin fails++; $display("FAIL lost_early: got %b expected 0", signal_lost); end
      end
      if (n == 3 + LOST_US * CF) begin
        tests++; if (signal_lost !== 1'b1) begin fails++; $display("FAIL lost_assert: got %b expected 1", signal_lost); end
      end
    end
    tests++; if (high_dur_out !== 15'd1490) begin fails++; $display("FAIL lost_hold_hd: got %0d expected 1490", high_dur_out); end
    send_pulse(1490);
    tests++; if (signal_lost !== 1'b0) begin fails++; $display("FAIL lost_clear: got %b expected 0", signal_lost); end
  endtask

  task automatic test_reset_mid_pulse();
    int v0;
    @(negedge clk);
    pwm = 1'b1;
    repeat (1000) @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (high_dur_out !== 15'd0 || angle_out !== 8'd0) begin fails++; $display("FAIL midrst_outputs: got %0d/%0d expected 0/0", high_dur_out, angle_out); end
    tests++; if (signal_lost !== 1'b1 || valid !== 1'b0) begin fails++; $display("FAIL midrst_flags: got lost %b valid %b expected 1 0", signal_lost, valid); end
    rst_n = 1'b1;
    v0 = valid_cnt;
    repeat (1000) @(negedge clk);
    pwm = 1'b0;
    repeat (SETTLE) @(negedge clk);
    tests++; if (valid_cnt !== v0) begin fails++; $display("FAIL midrst_skip: got %0d valid pulses expected 0", valid_cnt - v0); end
    tests++; if (high_dur_out !== 15'd0) begin fails++; $display("FAIL midrst_hold: got %0d expected 0", high_dur_out); end
    send_pulse(1000);
    tests++; if (valid_cnt !== v0 + 1) begin fails++; $display("FAIL midrst_next_valid: got %0d expected 1", valid_cnt - v0); end
    tests++; if (high_dur_out !== 15'd1000 || angle_out !== 8'd45) begin fails++; $display("FAIL midrst_next: got %0d/%0d expected 1000/45", high_dur_out, angle_out); end
    tests++; if (signal_lost !== 1'b0) begin fails++; $display("FAIL midrst_lost: got %b expected 0", signal_lost); end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    valid_cnt = 0;
    err_cnt   = 0;
    rst_n     = 1'b0;
    pwm       = 1'b0;
    test_reset();
    test_center();
    test_sweep();
    test_limits();
    test_range_short();
    test_stuck_high();
    test_signal_lost();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
